dpram_arb_4096_40bit: RTL and testbench

Four-requester round-robin arbiter that shares one 4096 x 40-bit dual-port RAM (port A and port B, 1-cycle registered read, write-or-read per port per cycle) between four independent clients. Each cycle it grants up to two non-conflicting requests, one per RAM port, and registers the RAM command. It returns read data tagged to the issuing requester two cycles after acceptance. It sits between compute-tile clients (weight/activation fetchers, result writers) and the shared RAM instance.

---
 rtl/dpram_arb_4096_40bit.sv | 174 +++++++++++++++++
 tb/tb_dpram_arb_4096_40bit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_arb_4096_40bit.sv
// dpram_arb_4096_40bit
// Round-robin arbiter that lets four clients share one dual-port RAM
// (4096 x 40, 1-cycle registered read). Up to two non-conflicting requests
// are granted per cycle, one on each RAM port. The RAM command is
// registered, and read data comes back tagged to the requester two cycles
// after acceptance.
//
// Ports
//   clk, resetn          : clock (rising edge), asynchronous active-low reset
//   req/we               : per-requester request valid and write select
//   addr/wdata           : per-requester address/data, lane i at [i*W +: W]
//   gnt                  : combinational grant, request i accepted this cycle
//   rvalid/rdata         : per-requester read response, rdata packed per lane
//   ram_address_x/ram_wren_x/ram_data_x : registered RAM command, ports a/b
//   ram_out_a/ram_out_b  : RAM read outputs
module dpram_arb_4096_40bit #(
   parameter int AWIDTH = 12,
   parameter int DWIDTH = 40,
   parameter int NREQ   = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          we,
   input  logic [NREQ*AWIDTH-1:0]   addr,
   input  logic [NREQ*DWIDTH-1:0]   wdata,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          rvalid,
   output logic [NREQ*DWIDTH-1:0]   rdata,
   output logic [AWIDTH-1:0]        ram_address_a,
   output logic [AWIDTH-1:0]        ram_address_b,
   output logic                     ram_wren_a,
   output logic                     ram_wren_b,
   output logic [DWIDTH-1:0]        ram_data_a,
   output logic [DWIDTH-1:0]        ram_data_b,
   input  logic [DWIDTH-1:0]        ram_out_a,
   input  logic [DWIDTH-1:0]        ram_out_b
);

   logic [1:0]          rr_ptr;

   logic [AWIDTH-1:0]   addr_arr  [NREQ];
   logic [DWIDTH-1:0]   wdata_arr [NREQ];

   logic                slot_a_vld;
   logic                slot_b_vld;
   logic [1:0]          slot_a_id;
   logic [1:0]          slot_b_id;
   logic [1:0]          cand;

   // Read tags {valid, id}: stage 1 while the RAM sees the address,
   // stage 2 while the RAM output is valid.
   logic [2:0]          tag1_a;
   logic [2:0]          tag1_b;
   logic [2:0]          tag2_a;
   logic [2:0]          tag2_b;

   logic [NREQ*DWIDTH-1:0] rdata_q;
   logic [NREQ*DWIDTH-1:0] rdata_next;

   // Unpack the per-requester lanes so they can be indexed by requester id.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         addr_arr[i]  = addr[i*AWIDTH +: AWIDTH];
         wdata_arr[i] = wdata[i*DWIDTH +: DWIDTH];
      end
   end

   // Scan from rr_ptr: the first requester takes slot A, the next one that
   // does not clash with slot A takes slot B. A clash (same address with at
   // least one write) skips that candidate and keeps scanning, so two reads
   // of the same address can still share a cycle.
   always_comb begin
      slot_a_vld = 1'b0;
      slot_b_vld = 1'b0;
      slot_a_id  = 2'd0;
      slot_b_id  = 2'd0;
      cand       = 2'd0;
      gnt        = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = rr_ptr + 2'(k);
         if (req[cand]) begin
            if (!slot_a_vld) begin
               slot_a_vld = 1'b1;
               slot_a_id  = cand;
            end else if (!slot_b_vld &&
                         !((addr_arr[cand] == addr_arr[slot_a_id]) &&
                           (we[cand] || we[slot_a_id]))) begin
               slot_b_vld = 1'b1;
               slot_b_id  = cand;
            end
         end
      end
      if (slot_a_vld) gnt[slot_a_id] = 1'b1;
      if (slot_b_vld) gnt[slot_b_id] = 1'b1;
   end

   // Pointer moves past the last granted slot; the RAM command registers
   // take the slotted requests, address/data hold when a slot is empty.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rr_ptr        <= 2'd0;
         ram_address_a <= '0;
         ram_address_b <= '0;
         ram_data_a    <= '0;
         ram_data_b    <= '0;
         ram_wren_a    <= 1'b0;
         ram_wren_b    <= 1'b0;
      end else begin
         if (slot_b_vld)
            rr_ptr <= slot_b_id + 2'd1;
         else if (slot_a_vld)
            rr_ptr <= slot_a_id + 2'd1;

         if (slot_a_vld) begin
            ram_address_a <= addr_arr[slot_a_id];
            ram_data_a    <= wdata_arr[slot_a_id];
            ram_wren_a    <= we[slot_a_id];
         end else begin
            ram_wren_a    <= 1'b0;
         end

         if (slot_b_vld) begin
            ram_address_b <= addr_arr[slot_b_id];
            ram_data_b    <= wdata_arr[slot_b_id];
            ram_wren_b    <= we[slot_b_id];
         end else begin
            ram_wren_b    <= 1'b0;
         end
      end
   end

   // Tag pipeline: only reads carry a valid tag, writes have no response.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tag1_a <= 3'd0;
         tag1_b <= 3'd0;
         tag2_a <= 3'd0;
         tag2_b <= 3'd0;
      end else begin
         tag1_a <= {slot_a_vld & ~we[slot_a_id], slot_a_id};
         tag1_b <= {slot_b_vld & ~we[slot_b_id], slot_b_id};
         tag2_a <= tag1_a;
         tag2_b <= tag1_b;
      end
   end

   // Steer each port's RAM output to the lane of the requester that issued
   // the read; other lanes keep their last value from rdata_q. Both ports'
   // stage-2 tags come from the same acceptance cycle, so they never name
   // the same requester.
   always_comb begin
      rvalid     = '0;
      rdata_next = rdata_q;
      if (tag2_a[2]) begin
         rvalid[tag2_a[1:0]] = 1'b1;
         rdata_next[tag2_a[1:0]*DWIDTH +: DWIDTH] = ram_out_a;
      end
      if (tag2_b[2]) begin
         rvalid[tag2_b[1:0]] = 1'b1;
         rdata_next[tag2_b[1:0]*DWIDTH +: DWIDTH] = ram_out_b;
      end
   end

   assign rdata = rdata_next;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         rdata_q <= '0;
      else
         rdata_q <= rdata_next;
   end

endmodule

// File: tb/tb_dpram_arb_4096_40bit.sv
// tb_dpram_arb_4096_40bit
// Directed self-checking bench for dpram_arb_4096_40bit. A behavioural
// dual-port RAM (registered read, write on wren) is attached to the DUT's
// RAM ports. Inputs change 1 time unit after the rising edge, and outputs
// are sampled before the next rising edge.
module tb_dpram_arb_4096_40bit;

   logic          clk;
   logic          resetn;
   logic [3:0]    req;
   logic [3:0]    we;
   logic [47:0]   addr;
   logic [159:0]  wdata;
   logic [3:0]    gnt;
   logic [3:0]    rvalid;
   logic [159:0]  rdata;
   logic [11:0]   ram_address_a;
   logic [11:0]   ram_address_b;
   logic          ram_wren_a;
   logic          ram_wren_b;
   logic [39:0]   ram_data_a;
   logic [39:0]   ram_data_b;
   logic [39:0]   ram_out_a;
   logic [39:0]   ram_out_b;

   logic [39:0]   mem [0:4095];

   int            n_cmp;
   int            n_err;

   dpram_arb_4096_40bit dut (
      .clk           (clk),
      .resetn        (resetn),
      .req           (req),
      .we            (we),
      .addr          (addr),
      .wdata         (wdata),
      .gnt           (gnt),
      .rvalid        (rvalid),
      .rdata         (rdata),
      .ram_address_a (ram_address_a),
      .ram_address_b (ram_address_b),
      .ram_wren_a    (ram_wren_a),
      .ram_wren_b    (ram_wren_b),
      .ram_data_a    (ram_data_a),
      .ram_data_b    (ram_data_b),
      .ram_out_a     (ram_out_a),
      .ram_out_b     (ram_out_b)
   );

   // Clock: 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Dual-port RAM model with one-cycle registered read per port.
   always @(posedge clk) begin
      if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
      if (ram_wren_b) mem[ram_address_b] <= ram_data_b;
      ram_out_a <= mem[ram_address_a];
      ram_out_b <= mem[ram_address_b];
   end

   // Guard against a stuck run.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic w, input logic [11:0] a, input logic [39:0] d);
      req[i]            = 1'b1;
      we[i]             = w;
      addr[i*12 +: 12]  = a;
      wdata[i*40 +: 40] = d;
   endtask

   task automatic clear_req();
      req = 4'b0000;
      we  = 4'b0000;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      clear_req();
      addr  = '0;
      wdata = '0;
      for (int c = 0; c < 3; c++) begin
         step();
         n_cmp++; if (rvalid !== 4'b0000) begin n_err++; $display("FAIL rst_rvalid: got %b want 0000", rvalid); end
         n_cmp++; if (ram_wren_a !== 1'b0 || ram_wren_b !== 1'b0) begin n_err++; $display("FAIL rst_wren: got %b%b want 00", ram_wren_a, ram_wren_b); end
         n_cmp++; if (ram_address_a !== 12'h000 || ram_address_b !== 12'h000) begin n_err++; $display("FAIL rst_addr: got %h/%h want 000/000", ram_address_a, ram_address_b); end
         n_cmp++; if (rdata !== 160'd0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", rdata); end
      end
      resetn = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL idle_gnt: got %b want 0000", gnt); end
         n_cmp++; if (rvalid !== 4'b0000) begin n_err++; $display("FAIL idle_rvalid: got %b want 0000", rvalid); end
         n_cmp++; if (ram_wren_a !== 1'b0 || ram_wren_b !== 1'b0) begin n_err++; $display("FAIL idle_wren: got %b%b want 00", ram_wren_a, ram_wren_b); end
         n_cmp++; if (dut.rr_ptr !== 2'd0) begin n_err++; $display("FAIL idle_rrptr: got %0d want 0", dut.rr_ptr); end
      end
   endtask

   task automatic test_write_read();
      set_req(0, 1'b1, 12'h123, 40'hA5A5A5A5A5);
      #1;
      n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL wr_gnt: got %b want 0001", gnt); end
      step();
      clear_req();
      n_cmp++; if (ram_wren_a !== 1'b1) begin n_err++; $display("FAIL wr_wren_a: got %b want 1", ram_wren_a); end
      n_cmp++; if (ram_address_a !== 12'h123) begin n_err++; $display("FAIL wr_addr_a: got %h want 123", ram_address_a); end
      n_cmp++; if (ram_data_a !== 40'hA5A5A5A5A5) begin n_err++; $display("FAIL wr_data_a: got %h want a5a5a5a5a5", ram_data_a); end
      n_cmp++; if (ram_wren_b !== 1'b0) begin n_err++; $display("FAIL wr_wren_b: got %b want 0", ram_wren_b); end
      step();
      set_req(0, 1'b0, 12'h123, 40'h0);
      #1;
      n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL rd_gnt: got %b want 0001", gnt); end
      n_cmp++; if (ram_wren_a !== 1'b0) begin n_err++; $display("FAIL rd_idle_wren: got %b want 0", ram_wren_a); end
      step();
      clear_req();
      n_cmp++; if (rvalid !== 4'b0000) begin n_err++; $display("FAIL rd_early: got %b want 0000", rvalid); end
      step();
      n_cmp++; if (rvalid !== 4'b0001) begin n_err++; $display("FAIL rd_rvalid: got %b want 0001", rvalid); end
      n_cmp++; if (rdata[39:0] !== 40'hA5A5A5A5A5) begin n_err++; $display("FAIL rd_data: got %h want a5a5a5a5a5", rdata[39:0]); end
      step();
      n_cmp++; if (rvalid !== 4'b0000) begin n_err++; $display("FAIL rd_once: got %b want 0000", rvalid); end
      n_cmp++; if (rdata[39:0] !== 40'hA5A5A5A5A5) begin n_err++; $display("FAIL rd_hold: got %h want a5a5a5a5a5", rdata[39:0]); end
   endtask

   task automatic test_fairness();
      logic [3:0]  pat [4];
      logic [3:0]  exp_g;
      logic [3:0]  exp_v;
      logic [39:0] exp_d;
      pat[0] = 4'b0011;
      pat[1] = 4'b1100;
      pat[2] = 4'b0011;
      pat[3] = 4'b1100;
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 12'h200 + 12'(i), 40'hC0DE000000 | 40'(i));
      #1;
      n_cmp++; if (gnt !== 4'b0011) begin n_err++; $display("FAIL fair_wr0: got %b want 0011", gnt); end
      step();
      req[0] = 1'b0;
      req[1] = 1'b0;
      #1;
      n_cmp++; if (gnt !== 4'b1100) begin n_err++; $display("FAIL fair_wr1: got %b want 1100", gnt); end
      step();
      clear_req();
      for (int k = 0; k < 6; k++) begin
         if (k < 4) begin
            for (int i = 0; i < 4; i++) set_req(i, 1'b0, 12'h200 + 12'(i), 40'h0);
         end else begin
            clear_req();
         end
         #1;
         exp_g = (k < 4) ? pat[k] : 4'b0000;
         exp_v = (k >= 2) ? pat[k-2] : 4'b0000;
         n_cmp++; if (gnt !== exp_g) begin n_err++; $display("FAIL fair_gnt%0d: got %b want %b", k, gnt, exp_g); end
         n_cmp++; if (rvalid !== exp_v) begin n_err++; $display("FAIL fair_rvalid%0d: got %b want %b", k, rvalid, exp_v); end
         for (int i = 0; i < 4; i++) begin
            if (exp_v[i]) begin
               exp_d = 40'hC0DE000000 | 40'(i);
               n_cmp++; if (rdata[i*40 +: 40] !== exp_d) begin n_err++; $display("FAIL fair_data%0d_%0d: got %h want %h", k, i, rdata[i*40 +: 40], exp_d); end
            end
         end
         step();
      end
   endtask

   task automatic test_conflict();
      set_req(0, 1'b1, 12'h010, 40'h123456789A);
      set_req(1, 1'b0, 12'h010, 40'h0);
      set_req(2, 1'b0, 12'h020, 40'h0);
      #1;
      n_cmp++; if (gnt !== 4'b0101) begin n_err++; $display("FAIL cf_gnt0: got %b want 0101", gnt); end
      step();
      req[0] = 1'b0;
      we[0]  = 1'b0;
      req[2] = 1'b0;
      #1;
      n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL cf_gnt1: got %b want 0010", gnt); end
      n_cmp++; if (ram_wren_a !== 1'b1 || ram_address_a !== 12'h010) begin n_err++; $display("FAIL cf_porta: got %b/%h want 1/010", ram_wren_a, ram_address_a); end
      n_cmp++; if (ram_wren_b !== 1'b0 || ram_address_b !== 12'h020) begin n_err++; $display("FAIL cf_portb: got %b/%h want 0/020", ram_wren_b, ram_address_b); end
      step();
      clear_req();
      n_cmp++; if (rvalid !== 4'b0100) begin n_err++; $display("FAIL cf_rvalid2: got %b want 0100", rvalid); end
      step();
      n_cmp++; if (rvalid !== 4'b0010) begin n_err++; $display("FAIL cf_rvalid1: got %b want 0010", rvalid); end
      n_cmp++; if (rdata[79:40] !== 40'h123456789A) begin n_err++; $display("FAIL cf_data1: got %h want 123456789a", rdata[79:40]); end
      step();
      n_cmp++; if (rvalid !== 4'b0000) begin n_err++; $display("FAIL cf_quiet: got %b want 0000", rvalid); end
   endtask

   task automatic test_same_addr();
      set_req(0, 1'b1, 12'hFFF, 40'h00000000FF);
      #1;
      n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL sa_wr_gnt: got %b want 0001", gnt); end
      step();
      clear_req();
      step();
      set_req(2, 1'b0, 12'hFFF, 40'h0);
      set_req(3, 1'b0, 12'hFFF, 40'h0);
      #1;
      n_cmp++; if (gnt !== 4'b1100) begin n_err++; $display("FAIL sa_gnt: got %b want 1100", gnt); end
      step();
      clear_req();
      step();
      n_cmp++; if (rvalid !== 4'b1100) begin n_err++; $display("FAIL sa_rvalid: got %b want 1100", rvalid); end
      n_cmp++; if (rdata[119:80] !== 40'hFF) begin n_err++; $display("FAIL sa_data2: got %h want ff", rdata[119:80]); end
      n_cmp++; if (rdata[159:120] !== 40'hFF) begin n_err++; $display("FAIL sa_data3: got %h want ff", rdata[159:120]); end
      step();
      n_cmp++; if (rvalid !== 4'b0000) begin n_err++; $display("FAIL sa_once: got %b want 0000", rvalid); end
      n_cmp++; if (rdata[159:120] !== 40'hFF) begin n_err++; $display("FAIL sa_hold: got %h want ff", rdata[159:120]); end
   endtask

   task automatic test_reset_midflight();
      set_req(0, 1'b0, 12'h123, 40'h0);
      set_req(1, 1'b0, 12'hFFF, 40'h0);
      #1;
      n_cmp++; if (gnt !== 4'b0011) begin n_err++; $display("FAIL mf_gnt: got %b want 0011", gnt); end
      step();
      clear_req();
      resetn = 1'b0;
      #1;
      n_cmp++; if (rvalid !== 4'b0000) begin n_err++; $display("FAIL mf_rvalid_rst: got %b want 0000", rvalid); end
      n_cmp++; if (ram_wren_a !== 1'b0 || ram_wren_b !== 1'b0) begin n_err++; $display("FAIL mf_wren: got %b%b want 00", ram_wren_a, ram_wren_b); end
      n_cmp++; if (ram_address_a !== 12'h000 || ram_address_b !== 12'h000) begin n_err++; $display("FAIL mf_addr: got %h/%h want 000/000", ram_address_a, ram_address_b); end
      n_cmp++; if (ram_data_a !== 40'h0 || ram_data_b !== 40'h0) begin n_err++; $display("FAIL mf_data: got %h/%h want 0/0", ram_data_a, ram_data_b); end
      n_cmp++; if (rdata !== 160'd0) begin n_err++; $display("FAIL mf_rdata: got %h want 0", rdata); end
      n_cmp++; if (dut.rr_ptr !== 2'd0) begin n_err++; $display("FAIL mf_rrptr: got %0d want 0", dut.rr_ptr); end
      step();
      resetn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         n_cmp++; if (rvalid !== 4'b0000) begin n_err++; $display("FAIL mf_after%0d: got %b want 0000", c, rvalid); end
         n_cmp++; if (rdata !== 160'd0) begin n_err++; $display("FAIL mf_rdata%0d: got %h want 0", c, rdata); end
         step();
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      resetn = 1'b0;
      req    = 4'b0000;
      we     = 4'b0000;
      addr   = '0;
      wdata  = '0;
      $display("[TB] start");
      test_reset();
      test_write_read();
      test_fairness();
      test_conflict();
      test_same_addr();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
